// File: rtl/imem_port_arbiter.sv
// Two-port arbiter for a single-port, synchronous-read instruction memory.
// Fetch (port 0) has fixed priority. A starvation counter forces a debug
// (port 1) grant after a bounded wait. A tag pipe routes each returned word
// back to the port that issued the read.
module imem_port_arbiter #(
  parameter int unsigned ADDR_W     = 30,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LAT        = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  input  logic              f_flush,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [2:0]        starve_cnt
);

  localparam int unsigned CNT_W = 3;

  logic [CNT_W-1:0]  starve_q, starve_d;
  logic [ADDR_W-1:0] last_addr_q;
  logic [LAT-1:0]    f_vld_q, f_vld_d;
  logic [LAT-1:0]    d_vld_q, d_vld_d;
  logic [DATA_W-1:0] f_rdata_q, d_rdata_q;

  // Grant decision: fetch wins unless debug has waited STARVE_MAX cycles.
  always_comb begin
    f_gnt = 1'b0;
    d_gnt = 1'b0;
    if (rst) begin
      if (d_req && (!f_req || (starve_q >= CNT_W'(STARVE_MAX)))) begin
        d_gnt = 1'b1;
      end else if (f_req) begin
        f_gnt = 1'b1;
      end
    end
  end

  // Memory address follows the grant; otherwise hold the last granted one.
  always_comb begin
    mem_addr = last_addr_q;
    if (f_gnt) begin
      mem_addr = f_addr;
    end else if (d_gnt) begin
      mem_addr = d_addr;
    end
  end

  // Starvation count: consecutive cycles debug was requesting but denied.
  always_comb begin
    starve_d = '0;
    if (d_req && !d_gnt) begin
      starve_d = (starve_q < CNT_W'(STARVE_MAX)) ? starve_q + CNT_W'(1) : starve_q;
    end
  end

  // Tag pipe next state: one valid lane per owner, flush empties the fetch lane.
  always_comb begin
    f_vld_d = '0;
    d_vld_d = '0;
    for (int i = int'(LAT) - 1; i > 0; i--) begin
      f_vld_d[i] = f_vld_q[i-1];
      d_vld_d[i] = d_vld_q[i-1];
    end
    f_vld_d[0] = f_gnt;
    d_vld_d[0] = d_gnt;
    if (f_flush) begin
      f_vld_d = '0;
    end
  end

  // Arbitration state and tag pipe registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q    <= '0;
      last_addr_q <= '0;
      f_vld_q     <= '0;
      d_vld_q     <= '0;
    end else begin
      starve_q <= starve_d;
      if (f_gnt || d_gnt) begin
        last_addr_q <= mem_addr;
      end
      f_vld_q <= f_vld_d;
      d_vld_q <= d_vld_d;
    end
  end

  // Hold copy of each port's last delivered word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (f_rvalid) begin
        f_rdata_q <= mem_rdata;
      end
      if (d_rvalid) begin
        d_rdata_q <= mem_rdata;
      end
    end
  end

  // Final pipe stage marks the cycle the memory word is valid for its owner.
  assign f_rvalid   = f_vld_q[LAT-1];
  assign d_rvalid   = d_vld_q[LAT-1];
  assign f_rdata    = f_rvalid ? mem_rdata : f_rdata_q;
  assign d_rdata    = d_rvalid ? mem_rdata : d_rdata_q;
  assign starve_cnt = starve_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: two instances (LAT=1 and LAT=2) share the same
// request stimulus, each with its own memory model; a transaction-level
// reference model predicts grants, addresses and responses.
module tb_imem_port_arbiter;

  localparam int unsigned AW = 30;
  localparam int unsigned DW = 32;
  localparam int SM = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          f_req = 1'b0, d_req = 1'b0, f_flush = 1'b0;
  logic [AW-1:0] f_addr = '0, d_addr = '0;

  logic          f_gnt_a, d_gnt_a, f_rvalid_a, d_rvalid_a;
  logic [DW-1:0] f_rdata_a, d_rdata_a, mem_rdata_a;
  logic [AW-1:0] mem_addr_a;
  logic [2:0]    starve_a;

  logic          f_gnt_b, d_gnt_b, f_rvalid_b, d_rvalid_b;
  logic [DW-1:0] f_rdata_b, d_rdata_b, mem_rdata_b, mem_pipe_b;
  logic [AW-1:0] mem_addr_b;
  logic [2:0]    starve_b;

  logic [DW-1:0] mem [16];

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  int            t = 0;
  int            s = 0;
  logic [AW-1:0] last_addr = '0;
  logic [DW-1:0] last_f [2];
  logic [DW-1:0] last_d [2];
  logic          rec_v [8];
  logic          rec_o [8];
  logic [3:0]    rec_a [8];
  logic          fl_h  [8];
  logic          e_fg, e_dg;

  always #5 clk = ~clk;

  imem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LAT(1), .STARVE_MAX(SM)) u_dut_a (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt_a), .f_flush(f_flush),
    .f_rvalid(f_rvalid_a), .f_rdata(f_rdata_a),
    .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt_a),
    .d_rvalid(d_rvalid_a), .d_rdata(d_rdata_a),
    .mem_addr(mem_addr_a), .mem_rdata(mem_rdata_a), .starve_cnt(starve_a)
  );

  imem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LAT(2), .STARVE_MAX(SM)) u_dut_b (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt_b), .f_flush(f_flush),
    .f_rvalid(f_rvalid_b), .f_rdata(f_rdata_b),
    .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt_b),
    .d_rvalid(d_rvalid_b), .d_rdata(d_rdata_b),
    .mem_addr(mem_addr_b), .mem_rdata(mem_rdata_b), .starve_cnt(starve_b)
  );

  // Synchronous-read memories with one and two cycles of latency
  always @(posedge clk) begin
    mem_rdata_a <= mem[mem_addr_a[3:0]];
    mem_pipe_b  <= mem[mem_addr_b[3:0]];
    mem_rdata_b <= mem_pipe_b;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, t);
    end
  endtask

  task automatic model_clear();
    s = 0;
    last_addr = '0;
    for (int i = 0; i < 2; i++) begin
      last_f[i] = '0;
      last_d[i] = '0;
    end
    for (int i = 0; i < 8; i++) begin
      rec_v[i] = 1'b0;
      fl_h[i]  = 1'b0;
    end
  endtask

  // One clock cycle: drive inputs, then check against the model.
  task automatic step(input logic fr, input logic [AW-1:0] fa,
                      input logic dr, input logic [AW-1:0] da, input logic fl);
    logic [AW-1:0] e_addr;
    logic          ev_f, ev_d, killed;
    logic [DW-1:0] data;
    int            g, idx, lat;
    @(negedge clk);
    f_req = fr; f_addr = fa; d_req = dr; d_addr = da; f_flush = fl;
    #1;
    e_dg   = dr && (!fr || s == SM);
    e_fg   = fr && !e_dg;
    e_addr = e_fg ? fa : (e_dg ? da : last_addr);
    chk("f_gnt_a", 32'(f_gnt_a), 32'(e_fg));
    chk("d_gnt_a", 32'(d_gnt_a), 32'(e_dg));
    chk("f_gnt_b", 32'(f_gnt_b), 32'(e_fg));
    chk("d_gnt_b", 32'(d_gnt_b), 32'(e_dg));
    chk("mem_addr_a", 32'(mem_addr_a), 32'(e_addr));
    chk("mem_addr_b", 32'(mem_addr_b), 32'(e_addr));
    chk("starve_a", 32'(starve_a), 32'(s));
    chk("starve_b", 32'(starve_b), 32'(s));
    rec_v[t % 8] = e_fg || e_dg;
    rec_o[t % 8] = e_dg;
    rec_a[t % 8] = e_addr[3:0];
    fl_h[t % 8]  = fl;
    for (int li = 0; li < 2; li++) begin
      lat  = li + 1;
      ev_f = 1'b0;
      ev_d = 1'b0;
      data = '0;
      if (t >= lat) begin
        g   = t - lat;
        idx = g % 8;
        data = mem[rec_a[idx]];
        if (rec_v[idx]) begin
          if (rec_o[idx]) begin
            ev_d = 1'b1;
          end else begin
            killed = 1'b0;
            for (int k = 0; k < lat; k++) killed |= fl_h[(g + k) % 8];
            ev_f = !killed;
          end
        end
      end
      if (ev_f) last_f[li] = data;
      if (ev_d) last_d[li] = data;
      if (li == 0) begin
        chk("f_rvalid_a", 32'(f_rvalid_a), 32'(ev_f));
        chk("d_rvalid_a", 32'(d_rvalid_a), 32'(ev_d));
        chk("f_rdata_a", f_rdata_a, last_f[0]);
        chk("d_rdata_a", d_rdata_a, last_d[0]);
      end else begin
        chk("f_rvalid_b", 32'(f_rvalid_b), 32'(ev_f));
        chk("d_rvalid_b", 32'(d_rvalid_b), 32'(ev_d));
        chk("f_rdata_b", f_rdata_b, last_f[1]);
        chk("d_rdata_b", d_rdata_b, last_d[1]);
      end
    end
    if (dr && !e_dg) s = (s < SM) ? s + 1 : s;
    else             s = 0;
    last_addr = e_addr;
    t++;
  endtask

  // Everything observable must read zero while reset is held.
  task automatic zero_checks();
    chk("rst f_gnt", 32'({f_gnt_a, f_gnt_b}), 32'd0);
    chk("rst d_gnt", 32'({d_gnt_a, d_gnt_b}), 32'd0);
    chk("rst rvalid", 32'({f_rvalid_a, d_rvalid_a, f_rvalid_b, d_rvalid_b}), 32'd0);
    chk("rst f_rdata_a", f_rdata_a, 32'd0);
    chk("rst d_rdata_a", d_rdata_a, 32'd0);
    chk("rst f_rdata_b", f_rdata_b, 32'd0);
    chk("rst d_rdata_b", d_rdata_b, 32'd0);
    chk("rst mem_addr_a", 32'(mem_addr_a), 32'd0);
    chk("rst mem_addr_b", 32'(mem_addr_b), 32'd0);
    chk("rst starve", 32'({starve_a, starve_b}), 32'd0);
  endtask

  // Asynchronous reset in the middle of a cycle, requests held high.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b0;
    f_req = 1'b1;
    d_req = 1'b1;
    #1;
    zero_checks();
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    f_req = 1'b0;
    d_req = 1'b0;
    f_flush = 1'b0;
  endtask

  initial begin
    logic          f_pend, d_pend, dp;
    logic [AW-1:0] f_a, d_a;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    mem[0]  = 32'h2409ffff;
    mem[1]  = 32'h40896000;
    mem[2]  = 32'h24170000;
    mem[12] = 32'h241100fd;
    model_clear();

    #3;
    zero_checks();
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Fetch only, consecutive addresses
    step(1'b1, 30'd0, 1'b0, 30'd0, 1'b0);
    step(1'b1, 30'd1, 1'b0, 30'd0, 1'b0);
    step(1'b1, 30'd2, 1'b0, 30'd0, 1'b0);
    step(1'b0, 30'd0, 1'b0, 30'd0, 1'b0);
    step(1'b0, 30'd0, 1'b0, 30'd0, 1'b0);

    // Starvation: fetch held, debug at 0xC waits for its forced grant
    dp = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 30'd3, dp, 30'hC, 1'b0);
      if (e_dg) dp = 1'b0;
    end
    step(1'b0, 30'd0, 1'b0, 30'd0, 1'b0);
    step(1'b0, 30'd0, 1'b0, 30'd0, 1'b0);

    // Flush the cycle after a fetch grant
    step(1'b1, 30'd5, 1'b0, 30'd0, 1'b0);
    step(1'b0, 30'd0, 1'b0, 30'd0, 1'b1);
    step(1'b0, 30'd0, 1'b0, 30'd0, 1'b0);
    step(1'b0, 30'd0, 1'b0, 30'd0, 1'b0);

    // Debug grant then fetch grant with same-cycle flush
    step(1'b0, 30'd0, 1'b1, 30'd9, 1'b0);
    step(1'b1, 30'd4, 1'b0, 30'd0, 1'b1);
    step(1'b0, 30'd0, 1'b0, 30'd0, 1'b0);
    step(1'b0, 30'd0, 1'b0, 30'd0, 1'b0);

    // Idle hold of the last granted address
    step(1'b1, 30'd7, 1'b0, 30'd0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 30'd0, 1'b0, 30'd0, 1'b0);

    // Reset with two reads in flight
    step(1'b1, 30'd2, 1'b0, 30'd0, 1'b0);
    step(1'b0, 30'd0, 1'b1, 30'd6, 1'b0);
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 30'd0, 1'b0, 30'd0, 1'b0);

    // Randomized traffic with occasional resets
    f_pend = 1'b0; d_pend = 1'b0; f_a = '0; d_a = '0;
    for (int c = 0; c < 1200; c++) begin
      if (!f_pend && ($urandom_range(0, 3) != 0)) begin
        f_pend = 1'b1;
        f_a = AW'($urandom_range(0, 15));
      end
      if (!d_pend && ($urandom_range(0, 3) == 0)) begin
        d_pend = 1'b1;
        d_a = AW'($urandom_range(0, 15));
      end
      step(f_pend, f_a, d_pend, d_a, ($urandom_range(0, 7) == 0));
      if (e_fg) f_pend = 1'b0;
      if (e_dg) d_pend = 1'b0;
      if ((c % 400) == 399) begin
        do_reset();
        f_pend = 1'b0;
        d_pend = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
- Shares the single-port, synchronous-read instruction memory between two requesters: instruction fetch (port 0) and the debug/loader read port (port 1).
- Fetch has fixed priority. A starvation counter forces a port-1 grant after a bounded wait.
- Tracks the owner of each in-flight read and routes returned data to the requester that issued it.
- Supports flushing in-flight fetch reads on a branch/redirect.

Parameters:
- ADDR_W, 30, word-address width
- DATA_W, 32, instruction width
- LAT, 1, memory read latency in cycles (address sampled on edge N, data valid during cycle N+LAT); legal 1..4
- STARVE_MAX, 4, consecutive denied cycles after which port 1 is granted

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  asynchronous, active-low reset
- f_req  in  1  fetch read request
- f_addr  in  ADDR_W  fetch word address
- f_gnt  out  1  fetch request accepted this cycle
- f_flush  in  1  discard all fetch reads in flight
- f_rvalid  out  1  fetch read data valid (one-cycle pulse)
- f_rdata  out  DATA_W  fetch read data
- d_req  in  1  debug read request
- d_addr  in  ADDR_W  debug word address
- d_gnt  out  1  debug request accepted this cycle
- d_rvalid  out  1  debug read data valid (one-cycle pulse)
- d_rdata  out  DATA_W  debug read data
- mem_addr  out  ADDR_W  address to memory, combinational from the grant
- mem_rdata  in  DATA_W  memory data, valid LAT cycles after the address is sampled
- starve_cnt  out  3  current starvation count, for debug visibility

Behaviour:
- Reset (rst low, asynchronous):
  - f_rvalid=0, d_rvalid=0, f_rdata=0, d_rdata=0.
  - starve_cnt=0, tag pipe cleared.
  - Last address register=0, so mem_addr=0.
  - Gnts are combinational, but forced 0 while rst is low.
- Grant rule, combinational, at most one gnt per cycle:
  - Only f_req: f_gnt=1.
  - Only d_req: d_gnt=1.
  - Both, starve_cnt<STARVE_MAX: f_gnt=1.
  - Both, starve_cnt==STARVE_MAX: d_gnt=1.
  - Neither: no gnt.
- mem_addr:
  - f_addr when f_gnt; d_addr when d_gnt.
  - Otherwise holds the last granted address (registered copy), keeping memory output stable.
- Starvation counter:
  - Increments when d_req=1 and d_gnt=0.
  - Clears to 0 on d_gnt, and when d_req=0.
  - Saturates at STARVE_MAX.
- Request semantics:
  - A requester holds req and addr stable until it sees gnt.
  - Exactly one read is issued per gnt.
  - Back-to-back grants every cycle are allowed (fully pipelined).
- Tag pipe: LAT-deep shift register of {valid, owner}. Stage 0 is loaded with the grant of the current cycle; stage LAT-1 drives the outputs.
- Response output, registered from stage LAT-1:
  - Owner=0: f_rvalid=1, f_rdata=mem_rdata.
  - Owner=1: d_rvalid=1, d_rdata=mem_rdata.
  - rdata of a port holds its last value when its rvalid=0.
  - No backpressure on responses.
  - End-to-end latency: gnt in cycle N gives rvalid in cycle N+LAT.
- Flush:
  - f_flush=1 clears the valid bit of every pipe entry with owner=0, including an f_gnt issued in the same cycle; the same-cycle f_gnt is still asserted.
  - Debug entries are unaffected.
  - Flush with nothing in flight is a no-op.
- Reset mid-operation: all in-flight reads are dropped with no rvalid. The first grant after reset release behaves as from idle.
- Simultaneous d_gnt and f_flush: the debug read completes normally.

Test Plan:
- Fetch only, LAT=1, f_req held with f_addr=0,1,2 on consecutive grants:
  - f_gnt=1 every cycle; mem_addr=0,1,2.
  - f_rvalid is 1 from the next cycle with f_rdata=mem_rdata per address (e.g. 0x2409ffff, 0x40896000, 0x24170000).
  - d_rvalid stays 0.
- Starvation: f_req held continuously, d_req asserted from cycle 0 with d_addr=0xC, STARVE_MAX=4:
  - starve_cnt counts 0,1,2,3,4.
  - d_gnt=1 in the cycle starve_cnt==4, with f_gnt=0 and mem_addr=0xC.
  - d_rvalid=1 one cycle later with d_rdata=0x241100fd.
  - starve_cnt returns to 0.
- Flush: fetch granted at addr 5 in cycle N with LAT=2, f_flush=1 in cycle N+1 -> no f_rvalid in cycle N+2.
- Mixed flush: d_gnt in cycle N, f_gnt in cycle N+1, f_flush in cycle N+1 -> d_rvalid in cycle N+LAT, no f_rvalid.
- Idle hold: after a grant at addr 7 and both reqs low -> mem_addr stays 7, no rvalid after the pipe drains.
- Async reset asserted while 2 reads are in flight (LAT=2):
  - Outputs go to 0 immediately, not at the next clock edge.
  - No rvalid appears after release.
  - mem_addr=0.
